cpu_memory: RTL and testbench
=============================

CPU_MEMORY -- requirements
Module: cpu_memory

Interface
REQ-001 Parameter ADDR_W, default 11, word address width; depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, word width; fixed at 4 bytes for boot assembly.
REQ-003 Parameter BOOT_EN, default 1; 0 means the boot loader is bypassed.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 read_mem_ir  input  1  instruction read enable from CPU.
REQ-007 mem_radrs_ir  input  ADDR_W  instruction read address.
REQ-008 instruction_fetch  output  DATA_W  instruction read data.
REQ-009 read_mem_str  input  1  load read enable from CPU.
REQ-010 mem_radrs_ld  input  ADDR_W  load read address.
REQ-011 mem_store_data  output  DATA_W  load read data.
REQ-012 write_mem  input  1  store write enable from CPU.
REQ-013 mem_wadrs  input  ADDR_W  store word address.
REQ-014 mem_wdata  input  DATA_W  store data.
REQ-015 boot_valid  input  1  boot byte present.
REQ-016 boot_data  input  8  boot byte, little-endian within the word.
REQ-017 boot_last  input  1  qualifies the final boot byte.
REQ-018 boot_ready  output  1  block accepts a boot byte this cycle.
REQ-019 cpu_resetn  output  1  active-low reset to CPU, registered.
REQ-020 boot_done  output  1  high in RUN state.

Function
REQ-021 The FSM SHALL have two states: LOAD and RUN; after reset it enters LOAD if BOOT_EN=1, else RUN.
REQ-022 In LOAD, boot_ready SHALL be 1 and a byte SHALL be accepted on every cycle with boot_valid=1.
REQ-023 Accepted bytes SHALL fill the assembly register low byte first; the byte counter wraps 3->0.
REQ-024 On the 4th byte, the word SHALL be written to array[boot_addr]; boot_addr increments by 1.
REQ-025 On boot_last with a partial word, the unfilled upper bytes SHALL be written as 0.
REQ-026 LOAD->RUN SHALL occur on the cycle after the write caused by boot_last, or after the word at address 2**ADDR_W-1 is written.
REQ-027 After address 2**ADDR_W-1, boot_addr SHALL NOT wrap; the FSM leaves LOAD and further bytes are not accepted.
REQ-028 In RUN, boot_ready SHALL be 0 and boot inputs SHALL be ignored.
REQ-029 In LOAD, CPU write_mem SHALL be ignored, and instruction_fetch and mem_store_data SHALL be 0.
REQ-030 cpu_resetn SHALL be 0 in reset and LOAD; it SHALL go to 1 one cycle after the state becomes RUN.
REQ-031 In RUN, when read_mem_ir=1, instruction_fetch SHALL equal array[mem_radrs_ir] one cycle later; otherwise it holds its last value.
REQ-032 In RUN, when read_mem_str=1, mem_store_data SHALL equal array[mem_radrs_ld] one cycle later; otherwise it holds its last value.
REQ-033 In RUN, when write_mem=1, array[mem_wadrs] SHALL be updated with mem_wdata at the clock edge.
REQ-034 A same-cycle read and write to one address SHALL return the new mem_wdata on both read ports (write-first).
REQ-035 Both read ports and the write port SHALL operate in the same cycle without stalling.
REQ-036 boot_done SHALL equal (state==RUN), registered.

Reset
REQ-037 On reset=1, the following SHALL be cleared: state (to LOAD, or RUN if BOOT_EN=0), byte counter and boot_addr (0), assembly register (0), instruction_fetch and mem_store_data (0), cpu_resetn (0), boot_done (0).
REQ-038 Array contents SHALL NOT be modified by reset.
REQ-039 A reset asserted mid-LOAD SHALL discard any partial word and restart loading at address 0.
REQ-040 A reset asserted in RUN SHALL re-enter LOAD when BOOT_EN=1.

Verification
REQ-041 Boot bytes 78 56 34 12 EF BE AD DE, boot_last on the last byte -> array[0]=0x12345678, array[1]=0xDEADBEEF; boot_done=1 on the next cycle; cpu_resetn=1 one cycle after that.
REQ-042 Boot bytes AA BB BB with boot_last on the third byte -> array[0]=0x00BBBBAA; FSM in RUN.
REQ-043 RUN: write 0xCAFEF00D to address 5 with a same-cycle load read of address 5 -> mem_store_data=0xCAFEF00D next cycle.
REQ-044 RUN: read_mem_ir with addresses 0 and 1 in consecutive cycles -> instruction_fetch = 0x12345678, then 0xDEADBEEF, each one cycle after its address.
REQ-045 Reset asserted after 2 boot bytes, then bytes 01 02 03 04 -> array[0]=0x04030201; LOAD active throughout until boot completes; cpu_resetn=0 until RUN.
REQ-046 BOOT_EN=0 -> RUN immediately after reset; boot_ready=0; write_mem is honoured on the first cycle after reset is released.

Source files
------------

// File: rtl/cpu_memory.sv
// -----------------------------------------------------------------------------
// cpu_memory
//   Word-addressed single-clock memory shared by a CPU and a byte-serial boot
//   loader. After reset the block sits in LOAD, where boot bytes are gathered
//   little-endian into words and written from address 0 upwards while the CPU
//   is held in reset. Once the last boot word is written (boot_last, or the
//   top address is filled) it moves to RUN. In RUN it serves one instruction
//   read port, one load read port and one store write port in the same cycle.
//
// Handshake: boot_ready is 1 exactly when the block is in LOAD. A boot byte
//   is taken on every rising edge where boot_ready && boot_valid. No byte is
//   ever stalled, so the source needs no back-pressure logic while in LOAD.
//
// Ports
//   clk, reset          sole clock; synchronous active-high reset
//   read_mem_ir         instruction read enable
//   mem_radrs_ir        instruction read address
//   instruction_fetch   registered instruction read data
//   read_mem_str        load read enable
//   mem_radrs_ld        load read address
//   mem_store_data      registered load read data
//   write_mem           store enable
//   mem_wadrs           store word address
//   mem_wdata           store data
//   boot_valid          boot byte present
//   boot_data           boot byte (little-endian within the word)
//   boot_last           marks the final boot byte
//   boot_ready          block takes a boot byte this cycle
//   cpu_resetn          registered active-low reset to the CPU
//   boot_done           registered "in RUN" flag
//   dbg_state_o         current FSM state (0 = LOAD, 1 = RUN)
// -----------------------------------------------------------------------------
module cpu_memory #(
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 32,
   parameter int BOOT_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read_mem_ir,
   input  logic [ADDR_W-1:0] mem_radrs_ir,
   output logic [DATA_W-1:0] instruction_fetch,
   input  logic              read_mem_str,
   input  logic [ADDR_W-1:0] mem_radrs_ld,
   output logic [DATA_W-1:0] mem_store_data,
   input  logic              write_mem,
   input  logic [ADDR_W-1:0] mem_wadrs,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              boot_valid,
   input  logic [7:0]        boot_data,
   input  logic              boot_last,
   output logic              boot_ready,
   output logic              cpu_resetn,
   output logic              boot_done,
   output logic              dbg_state_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam state_e RESET_STATE = (BOOT_EN != 0) ? ST_LOAD : ST_RUN;

   state_e            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
   logic [DATA_W-1:0] asm_q, asm_d;
   logic [DATA_W-1:0] ifetch_q, ldata_q;
   logic              cpu_resetn_q, boot_done_q;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              boot_acc;
   logic              boot_word_wr;
   logic [DATA_W-1:0] boot_word;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;

   // Word being completed by the current byte. asm_q only ever holds lanes
   // below byte_cnt_q, so the upper lanes come out as zero on a short last word.
   assign boot_acc     = (state_q == ST_LOAD) && boot_valid;
   assign boot_word_wr = boot_acc && ((byte_cnt_q == 2'd3) || boot_last);
   assign boot_word    = asm_q | (DATA_W'(boot_data) << {byte_cnt_q, 3'b000});

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if ((state_q == ST_LOAD) && boot_word_wr &&
          (boot_last || (boot_addr_q == LAST_ADDR))) begin
         state_d = ST_RUN;
      end
   end

   always_comb begin
      boot_ready  = (state_q == ST_LOAD);
      dbg_state_o = (state_q == ST_RUN);
   end

   // ---------------------------------------------------------- boot datapath
   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      boot_addr_d = boot_addr_q;
      asm_d       = asm_q;
      if (boot_acc) begin
         if (boot_word_wr) begin
            byte_cnt_d = 2'd0;
            asm_d      = '0;
            // Top address is a hard stop: the FSM leaves LOAD instead of wrapping.
            if (boot_addr_q != LAST_ADDR) begin
               boot_addr_d = boot_addr_q + ADDR_W'(1);
            end
         end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            asm_d      = boot_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt_q  <= 2'd0;
         boot_addr_q <= '0;
         asm_q       <= '0;
      end else begin
         byte_cnt_q  <= byte_cnt_d;
         boot_addr_q <= boot_addr_d;
         asm_q       <= asm_d;
      end
   end

   // ------------------------------------------------------------- write port
   // One physical write port: boot loader owns it in LOAD, the CPU in RUN.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = mem_wadrs;
      mem_wd = mem_wdata;
      if (!reset) begin
         if (state_q == ST_LOAD) begin
            mem_we = boot_word_wr;
            mem_wa = boot_addr_q;
            mem_wd = boot_word;
         end else begin
            mem_we = write_mem;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_wa] <= mem_wd;
      end
   end

   // -------------------------------------------------------------- read ports
   // Registered reads with write-first bypass from the CPU store port.
   always_ff @(posedge clk) begin
      if (reset || (state_q == ST_LOAD)) begin
         ifetch_q <= '0;
         ldata_q  <= '0;
      end else begin
         if (read_mem_ir) begin
            ifetch_q <= (write_mem && (mem_wadrs == mem_radrs_ir)) ?
                        mem_wdata : mem_q[mem_radrs_ir];
         end
         if (read_mem_str) begin
            ldata_q <= (write_mem && (mem_wadrs == mem_radrs_ld)) ?
                       mem_wdata : mem_q[mem_radrs_ld];
         end
      end
   end

   // ------------------------------------------------------- status outputs
   // boot_done rises with the state; cpu_resetn follows one cycle behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_resetn_q <= 1'b0;
         boot_done_q  <= 1'b0;
      end else begin
         cpu_resetn_q <= (state_q == ST_RUN);
         boot_done_q  <= (state_d == ST_RUN);
      end
   end

   assign instruction_fetch = ifetch_q;
   assign mem_store_data    = ldata_q;
   assign cpu_resetn        = cpu_resetn_q;
   assign boot_done         = boot_done_q;

endmodule

// File: tb/tb_cpu_memory.sv
module tb_cpu_memory;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // dut_a: default parameters
   logic        a_rir, a_rld, a_wr, a_bv, a_bl;
   logic [10:0] a_air, a_ald, a_aw;
   logic [31:0] a_wd, a_if, a_ls;
   logic [7:0]  a_bd;
   logic        a_br, a_crn, a_bdn, a_st;

   // dut_b: boot bypassed, small array
   logic        b_rir, b_rld, b_wr, b_bv, b_bl;
   logic [3:0]  b_air, b_ald, b_aw;
   logic [31:0] b_wd, b_if, b_ls;
   logic [7:0]  b_bd;
   logic        b_br, b_crn, b_bdn, b_st;

   // dut_c: 8-word array for the full-array boot case
   logic        c_rir, c_rld, c_wr, c_bv, c_bl;
   logic [2:0]  c_air, c_ald, c_aw;
   logic [31:0] c_wd, c_if, c_ls;
   logic [7:0]  c_bd;
   logic        c_br, c_crn, c_bdn, c_st;

   cpu_memory dut_a (
      .clk(clk), .reset(reset),
      .read_mem_ir(a_rir), .mem_radrs_ir(a_air), .instruction_fetch(a_if),
      .read_mem_str(a_rld), .mem_radrs_ld(a_ald), .mem_store_data(a_ls),
      .write_mem(a_wr), .mem_wadrs(a_aw), .mem_wdata(a_wd),
      .boot_valid(a_bv), .boot_data(a_bd), .boot_last(a_bl), .boot_ready(a_br),
      .cpu_resetn(a_crn), .boot_done(a_bdn), .dbg_state_o(a_st));

   cpu_memory #(.ADDR_W(4), .DATA_W(32), .BOOT_EN(0)) dut_b (
      .clk(clk), .reset(reset),
      .read_mem_ir(b_rir), .mem_radrs_ir(b_air), .instruction_fetch(b_if),
      .read_mem_str(b_rld), .mem_radrs_ld(b_ald), .mem_store_data(b_ls),
      .write_mem(b_wr), .mem_wadrs(b_aw), .mem_wdata(b_wd),
      .boot_valid(b_bv), .boot_data(b_bd), .boot_last(b_bl), .boot_ready(b_br),
      .cpu_resetn(b_crn), .boot_done(b_bdn), .dbg_state_o(b_st));

   cpu_memory #(.ADDR_W(3), .DATA_W(32), .BOOT_EN(1)) dut_c (
      .clk(clk), .reset(reset),
      .read_mem_ir(c_rir), .mem_radrs_ir(c_air), .instruction_fetch(c_if),
      .read_mem_str(c_rld), .mem_radrs_ld(c_ald), .mem_store_data(c_ls),
      .write_mem(c_wr), .mem_wadrs(c_aw), .mem_wdata(c_wd),
      .boot_valid(c_bv), .boot_data(c_bd), .boot_last(c_bl), .boot_ready(c_br),
      .cpu_resetn(c_crn), .boot_done(c_bdn), .dbg_state_o(c_st));

   // Reference contents of dut_a addresses 0..15
   logic [31:0] ma [16];
   logic [31:0] exp_if, exp_ls;
   logic [7:0]  cb [32];
   logic [7:0]  bb [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_word(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
      return 32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24);
   endfunction

   task automatic a_boot(input logic [7:0] b, input logic last);
      a_bv = 1'b1; a_bd = b; a_bl = last;
      tick();
      a_bv = 1'b0; a_bl = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      {a_rir, a_rld, a_wr, a_bv, a_bl} = '0; a_air = '0; a_ald = '0; a_aw = '0; a_wd = '0; a_bd = '0;
      {b_rir, b_rld, b_wr, b_bv, b_bl} = '0; b_air = '0; b_ald = '0; b_aw = '0; b_wd = '0; b_bd = '0;
      {c_rir, c_rld, c_wr, c_bv, c_bl} = '0; c_air = '0; c_ald = '0; c_aw = '0; c_wd = '0; c_bd = '0;
      repeat (2) tick();

      // Reset state
      check("rst_a_ifetch", a_if, 32'd0);
      check("rst_a_ldata", a_ls, 32'd0);
      check("rst_a_cpu_resetn", 32'(a_crn), 32'd0);
      check("rst_a_boot_done", 32'(a_bdn), 32'd0);
      check("rst_a_state_load", 32'(a_st), 32'd0);
      check("rst_b_boot_done", 32'(b_bdn), 32'd0);
      check("rst_b_cpu_resetn", 32'(b_crn), 32'd0);
      check("rst_b_ready", 32'(b_br), 32'd0);

      // Boot bypassed: store honoured on the very first cycle out of reset
      begin
         logic [31:0] bv;
         bv = $urandom;
         reset = 1'b0; b_wr = 1'b1; b_aw = 4'd3; b_wd = bv;
         b_bv = 1'b1; b_bd = 8'h5A;
         tick();
         b_wr = 1'b0; b_bv = 1'b0;
         check("b_boot_done", 32'(b_bdn), 32'd1);
         b_rld = 1'b1; b_ald = 4'd3;
         tick();
         b_rld = 1'b0;
         check("b_first_write", b_ls, bv);
         check("b_cpu_resetn", 32'(b_crn), 32'd1);
         check("b_ready_low", 32'(b_br), 32'd0);
      end

      // Reset mid-LOAD discards the partial word
      a_boot(8'($urandom), 1'b0);
      a_boot(8'($urandom), 1'b0);
      check("midload_state", 32'(a_st), 32'd0);
      pulse_reset();
      check("midload_rst_state", 32'(a_st), 32'd0);
      check("midload_rst_crn", 32'(a_crn), 32'd0);
      for (int i = 0; i < 4; i++) begin
         a_boot(8'(i + 1), (i == 3));
         if (i < 3) begin
            check("midload_load", 32'(a_st), 32'd0);
            check("midload_ready", 32'(a_br), 32'd1);
            check("midload_crn", 32'(a_crn), 32'd0);
         end
      end
      check("midload_run", 32'(a_st), 32'd1);
      check("midload_done", 32'(a_bdn), 32'd1);
      check("midload_crn_lag", 32'(a_crn), 32'd0);
      tick();
      check("midload_crn_up", 32'(a_crn), 32'd1);
      a_rir = 1'b1; a_air = 11'd0;
      tick();
      a_rir = 1'b0;
      check("midload_word0", a_if, 32'h04030201);

      // Short last word is zero-padded
      pulse_reset();
      a_boot(8'hAA, 1'b0);
      a_boot(8'hBB, 1'b0);
      a_boot(8'hBB, 1'b1);
      check("partial_run", 32'(a_st), 32'd1);
      a_rld = 1'b1; a_ald = 11'd0;
      tick();
      a_rld = 1'b0;
      check("partial_word0", a_ls, 32'h00BBBBAA);

      // Two-word boot
      pulse_reset();
      bb[0] = 8'h78; bb[1] = 8'h56; bb[2] = 8'h34; bb[3] = 8'h12;
      for (int i = 0; i < 4; i++) a_boot(bb[i], 1'b0);
      bb[0] = 8'hEF; bb[1] = 8'hBE; bb[2] = 8'hAD; bb[3] = 8'hDE;
      for (int i = 0; i < 4; i++) a_boot(bb[i], (i == 3));
      check("boot2_done", 32'(a_bdn), 32'd1);
      check("boot2_crn_lag", 32'(a_crn), 32'd0);
      tick();
      check("boot2_crn_up", 32'(a_crn), 32'd1);
      ma[0] = mk_word(8'h78, 8'h56, 8'h34, 8'h12);
      ma[1] = mk_word(8'hEF, 8'hBE, 8'hAD, 8'hDE);
      a_rir = 1'b1; a_air = 11'd0;
      tick();
      check("ifetch_addr0", a_if, ma[0]);
      a_air = 11'd1;
      tick();
      a_rir = 1'b0;
      check("ifetch_addr1", a_if, ma[1]);

      // Write-first on both read ports
      a_wr = 1'b1; a_aw = 11'd5; a_wd = 32'hCAFEF00D;
      a_rld = 1'b1; a_ald = 11'd5; a_rir = 1'b1; a_air = 11'd5;
      tick();
      {a_wr, a_rld, a_rir} = '0;
      ma[5] = 32'hCAFEF00D;
      check("wfirst_ld", a_ls, 32'hCAFEF00D);
      check("wfirst_ir", a_if, 32'hCAFEF00D);
      exp_if = 32'hCAFEF00D;
      exp_ls = 32'hCAFEF00D;

      // Fill 2..15 with known data
      for (int k = 2; k < 16; k++) begin
         ma[k] = $urandom;
         a_wr = 1'b1; a_aw = 11'(k); a_wd = ma[k];
         tick();
      end
      a_wr = 1'b0;

      // Random concurrent traffic against the reference array
      for (int n = 0; n < 300; n++) begin
         int ra, rl, wa;
         ra = $urandom_range(0, 15);
         rl = $urandom_range(0, 15);
         wa = $urandom_range(0, 15);
         a_rir = 1'($urandom_range(0, 1));
         a_rld = 1'($urandom_range(0, 1));
         a_wr  = 1'($urandom_range(0, 1));
         a_air = 11'(ra); a_ald = 11'(rl); a_aw = 11'(wa); a_wd = $urandom;
         if (a_rir) exp_if = (a_wr && wa == ra) ? a_wd : ma[ra];
         if (a_rld) exp_ls = (a_wr && wa == rl) ? a_wd : ma[rl];
         if (a_wr) ma[wa] = a_wd;
         tick();
         check("rand_ifetch", a_if, exp_if);
         check("rand_ldata", a_ls, exp_ls);
      end
      {a_rir, a_rld, a_wr} = '0;

      // Boot inputs ignored in RUN
      for (int n = 0; n < 6; n++) begin
         a_bv = 1'b1; a_bd = 8'($urandom); a_bl = 1'($urandom_range(0, 1));
         tick();
         check("run_ready_low", 32'(a_br), 32'd0);
         check("run_state", 32'(a_st), 32'd1);
      end
      a_bv = 1'b0; a_bl = 1'b0;
      a_rir = 1'b1; a_air = 11'd0;
      tick();
      a_rir = 1'b0;
      check("run_boot_ignored", a_if, ma[0]);

      // Reset from RUN re-enters LOAD; CPU store and reads ignored in LOAD
      pulse_reset();
      check("rerun_load", 32'(a_st), 32'd0);
      check("rerun_ready", 32'(a_br), 32'd1);
      check("rerun_if_clr", a_if, 32'd0);
      check("rerun_ls_clr", a_ls, 32'd0);
      a_wr = 1'b1; a_aw = 11'd7; a_wd = ~ma[7];
      a_rir = 1'b1; a_air = 11'd7; a_rld = 1'b1; a_ald = 11'd7;
      tick();
      {a_wr, a_rir, a_rld} = '0;
      check("load_if_zero", a_if, 32'd0);
      check("load_ls_zero", a_ls, 32'd0);
      for (int i = 0; i < 4; i++) bb[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) a_boot(bb[i], (i == 3));
      ma[0] = mk_word(bb[0], bb[1], bb[2], bb[3]);
      check("reboot_run", 32'(a_st), 32'd1);
      a_rir = 1'b1; a_air = 11'd7; a_rld = 1'b1; a_ald = 11'd1;
      tick();
      a_air = 11'd0;
      check("load_write_ignored", a_if, ma[7]);
      check("array_kept_by_reset", a_ls, ma[1]);
      tick();
      {a_rir, a_rld} = '0;
      check("reboot_word0", a_if, ma[0]);

      // Full-array boot on dut_c: stops at the top address, no wrap
      for (int i = 0; i < 32; i++) cb[i] = 8'($urandom);
      for (int i = 0; i < 32; i++) begin
         check("full_ready", 32'(c_br), 32'd1);
         c_bv = 1'b1; c_bd = cb[i];
         tick();
      end
      check("full_run", 32'(c_st), 32'd1);
      check("full_done", 32'(c_bdn), 32'd1);
      for (int i = 0; i < 4; i++) begin
         c_bd = 8'($urandom);
         tick();
         check("full_ready_low", 32'(c_br), 32'd0);
      end
      c_bv = 1'b0;
      check("full_crn", 32'(c_crn), 32'd1);
      for (int k = 0; k < 8; k++) begin
         c_rir = 1'b1; c_air = 3'(k);
         c_rld = 1'b1; c_ald = 3'(7 - k);
         tick();
         check("full_ir_word", c_if, mk_word(cb[4*k], cb[4*k+1], cb[4*k+2], cb[4*k+3]));
         check("full_ld_word", c_ls, mk_word(cb[4*(7-k)], cb[4*(7-k)+1], cb[4*(7-k)+2], cb[4*(7-k)+3]));
      end
      {c_rir, c_rld} = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
